lsu_ctrl: RTL and testbench

Load/store control unit between the execute stage and the data memory. It accepts one load or store request at a time over a valid/ready handshake and checks alignment and address range. It drives the memory's word/byte write codes, splitting halfword stores into two byte writes. It sign- or zero-extends load data itself and returns one response pulse per request.

---
 rtl/lsu_ctrl_if.sv | 33 +++
 rtl/lsu_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
interface lsu_ctrl_if;
  // Execute-stage request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  // Completion
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  // Data memory
  logic [15:0] Ad;
  logic [31:0] WrData;
  logic [2:0]  MemWr;
  logic [1:0]  DMcut_sel;
  logic [31:0] DM;

  // Unit side
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, DM,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, Ad, WrData, MemWr, DMcut_sel
  );

  // Requester / memory side
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, DM,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, Ad, WrData, MemWr, DMcut_sel
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control unit: one request at a time, alignment/range checking,
// halfword stores split into two byte writes, load data extended locally.
module lsu_ctrl #(
  parameter logic [15:0] ADDR_LO = 16'hFF00
) (
  input  logic       Clk,
  input  logic       Reset,
  lsu_ctrl_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc0 = 2'd1;
  localparam logic [1:0] StAcc1 = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;
  localparam logic [1:0] SzBad  = 2'd3;

  localparam logic [2:0] WrNone = 3'd0;
  localparam logic [2:0] WrWord = 3'd1;
  localparam logic [2:0] WrByte = 3'd2;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_fault;
  logic [31:0] load_ext;

  // Fault decision is made from the live request fields at acceptance.
  always_comb begin
    req_fault = 1'b0;
    if (bus.req_size == SzBad) req_fault = 1'b1;
    if (bus.req_addr < ADDR_LO) req_fault = 1'b1;
    if (bus.req_size == SzHalf && bus.req_addr[0]) req_fault = 1'b1;
    if (bus.req_size == SzWord && bus.req_addr[1:0] != 2'b00) req_fault = 1'b1;
  end

  // Extract the big-endian leading bytes of DM so unused bytes never propagate.
  always_comb begin
    unique case (size_q)
      SzByte:  load_ext = {{24{signed_q & bus.DM[31]}}, bus.DM[31:24]};
      SzHalf:  load_ext = {{16{signed_q & bus.DM[31]}}, bus.DM[31:16]};
      default: load_ext = bus.DM;
    endcase
  end

  // Next-state and request/load register updates.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          fault_d  = req_fault;
          rdata_d  = 32'h0;
          state_d  = req_fault ? StResp : StAcc0;
        end
      end
      StAcc0: begin
        if (!we_q) begin
          rdata_d = load_ext;
          state_d = StResp;
        end else if (size_q == SzHalf) begin
          state_d = StAcc1;
        end else begin
          state_d = StResp;
        end
      end
      StAcc1: state_d = StResp;
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous abort to IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= 16'h0;
      wdata_q  <= 32'h0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
    end
  end

  // Handshake and response outputs; response fields are zero outside RESP.
  always_comb begin
    bus.req_ready = (state_q == StIdle) && !Reset;
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_rdata = (state_q == StResp) ? rdata_q : 32'h0;
    bus.rsp_fault = (state_q == StResp) ? fault_q : 1'b0;
  end

  // Memory bus drive; idle outside the access states.
  always_comb begin
    bus.Ad        = 16'h0;
    bus.WrData    = 32'h0;
    bus.MemWr     = WrNone;
    bus.DMcut_sel = 2'd0;
    unique case (state_q)
      StAcc0: begin
        bus.Ad = addr_q;
        if (we_q) begin
          unique case (size_q)
            SzWord: begin
              bus.MemWr  = WrWord;
              bus.WrData = wdata_q;
            end
            SzHalf: begin
              bus.MemWr  = WrByte;
              bus.WrData = {24'h0, wdata_q[15:8]};
            end
            default: begin
              bus.MemWr  = WrByte;
              bus.WrData = {24'h0, wdata_q[7:0]};
            end
          endcase
        end
      end
      StAcc1: begin
        // Odd half addresses fault, so this increment cannot wrap.
        bus.Ad     = addr_q + 16'd1;
        bus.MemWr  = WrByte;
        bus.WrData = {24'h0, wdata_q[7:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-array memory model, reference model of
// the load/store rules, response and memory-write monitors.
module tb_lsu_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  lsu_ctrl_if bus ();
  lsu_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          at;
  } rsp_t;

  typedef struct {
    logic [15:0] ad;
    logic [2:0]  code;
    logic [31:0] data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  logic [7:0] mem [0:255];
  logic [7:0] ref_mem [0:255];
  logic       mem_init_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Data memory covering 16'hFF00..16'hFFFF; writes commit on the clock edge.
  always @(posedge Clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'((i * 37 + 11) & 255);
      mem_init_done <= 1'b1;
    end else if (bus.Ad >= 16'hFF00) begin
      if (bus.MemWr == 3'd1) begin
        mem[bus.Ad[7:0]]         <= bus.WrData[31:24];
        mem[bus.Ad[7:0] + 8'd1]  <= bus.WrData[23:16];
        mem[bus.Ad[7:0] + 8'd2]  <= bus.WrData[15:8];
        mem[bus.Ad[7:0] + 8'd3]  <= bus.WrData[7:0];
      end else if (bus.MemWr == 3'd2) begin
        mem[bus.Ad[7:0]] <= bus.WrData[7:0];
      end
    end
  end

  // Combinational big-endian read; bytes outside the legal range read as X.
  logic [7:0]  dm_b [0:3];
  logic [15:0] dm_a;
  always_comb begin
    dm_a = 16'h0;
    for (int i = 0; i < 4; i++) begin
      dm_a = bus.Ad + 16'(i);
      dm_b[i] = (dm_a >= 16'hFF00) ? mem[dm_a[7:0]] : 8'hxx;
    end
    bus.DM = {dm_b[0], dm_b[1], dm_b[2], dm_b[3]};
  end

  // Response monitor.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rsp_fault", 32'(bus.rsp_fault), 32'(e.fault));
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_cycle", 32'(cyc), 32'(e.at));
          chk("ready_low_in_resp", 32'(bus.req_ready), 32'd0);
        end
      end else begin
        chk("rsp_fields_idle", {bus.rsp_rdata[30:0], bus.rsp_fault}, 32'd0);
      end
    end
  end

  // Memory-write monitor.
  always @(negedge Clk) begin
    if (!Reset && bus.MemWr != 3'd0) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.MemWr), 32'd0);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", 32'(bus.Ad), 32'(w.ad));
        chk("wr_code", 32'(bus.MemWr), 32'(w.code));
        chk("wr_data", bus.WrData, w.data);
      end
    end
  end

  function automatic logic [7:0] rb(input logic [15:0] a);
    return ref_mem[a - 16'hFF00];
  endfunction

  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [15:0] addr, input logic [31:0] wd,
                        input bit ovr, input logic [31:0] ovr_val, input bit abort);
    bit   fault;
    int   lat;
    int   v;
    int   n;
    rsp_t e;
    fault = (size == 3) || (addr < 16'hFF00) || (size == 1 && addr % 2 != 0) ||
            (size == 2 && addr % 4 != 0);
    e.fault = fault;
    e.rdata = 32'h0;
    lat = fault ? 1 : ((we && size == 1) ? 3 : 2);
    if (!fault && !we) begin
      if (size == 0) begin
        v = int'(rb(addr));
        if (sgn && v > 127) v -= 256;
      end else if (size == 1) begin
        v = int'(rb(addr)) * 256 + int'(rb(addr + 16'd1));
        if (sgn && v > 32767) v -= 65536;
      end else begin
        v = int'({rb(addr), rb(addr + 16'd1), rb(addr + 16'd2), rb(addr + 16'd3)});
      end
      e.rdata = ovr ? ovr_val : 32'(v);
    end
    @(negedge Clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    e.at = cyc + lat;
    if (!abort) rsp_q.push_back(e);
    if (!fault && we) begin
      if (size == 2) begin
        wr_q.push_back('{ad: addr, code: 3'd1, data: wd});
        ref_mem[addr - 16'hFF00]        = wd[31:24];
        ref_mem[addr - 16'hFF00 + 16'd1] = wd[23:16];
        ref_mem[addr - 16'hFF00 + 16'd2] = wd[15:8];
        ref_mem[addr - 16'hFF00 + 16'd3] = wd[7:0];
      end else if (size == 0) begin
        wr_q.push_back('{ad: addr, code: 3'd2, data: {24'h0, wd[7:0]}});
        ref_mem[addr - 16'hFF00] = wd[7:0];
      end else begin
        wr_q.push_back('{ad: addr, code: 3'd2, data: {24'h0, wd[15:8]}});
        ref_mem[addr - 16'hFF00] = wd[15:8];
        if (!abort) begin
          wr_q.push_back('{ad: addr + 16'd1, code: 3'd2, data: {24'h0, wd[7:0]}});
          ref_mem[addr - 16'hFF00 + 16'd1] = wd[7:0];
        end
      end
    end
    @(negedge Clk);
    bus.req_valid = 1'b0;
    if (abort) begin
      // First byte commits at the next edge; reset lands in the second-byte cycle.
      @(posedge Clk);
      #1 Reset = 1'b1;
      #1;
      chk("abort_memwr_zero", 32'(bus.MemWr), 32'd0);
      chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
      return;
    end
    n = 0;
    while (rsp_q.size() != 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (rsp_q.size() != 0) begin
      chk("rsp_timeout", 32'(rsp_q.size()), 32'd0);
      rsp_q.delete();
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [1:0]  sz;
    int          nbad;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);

    repeat (3) @(negedge Clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp", {bus.rsp_rdata[30:0], bus.rsp_valid}, 32'd0);
    chk("rst_fault", 32'(bus.rsp_fault), 32'd0);
    chk("rst_mem_bus", {bus.Ad, 11'h0, bus.MemWr, bus.DMcut_sel}, 32'd0);
    chk("rst_wrdata", bus.WrData, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);

    do_req(1'b1, 2'd2, 1'b0, 16'hFF10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 16'hFF10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 16'hFF10, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 16'hFF12, 32'h0, 1'b1, 32'h0000BEEF, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 16'hFF12, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 16'hFF20, 32'h00001234, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 16'hFF20, 32'h0, 1'b1, 32'h00001234, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 16'hFF20, 32'h0, 1'b0, 32'h0, 1'b0);
    do_req(1'b1, 2'd2, 1'b0, 16'hFF11, 32'h11223344, 1'b0, 32'h0, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 16'hFF21, 32'h00005566, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 16'h00FF, 32'h0, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 16'hFF40, 32'h0, 1'b0, 32'h0, 1'b0);
    do_req(1'b1, 2'd3, 1'b0, 16'hFF40, 32'h77777777, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 16'hFFFF, 32'h0, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 16'hFFFE, 32'h0, 1'b0, 32'h0, 1'b0);

    do_req(1'b1, 2'd1, 1'b0, 16'hFF30, 32'h0000A5C3, 1'b0, 32'h0, 1'b1);
    chk("abort_first_byte", 32'(mem[8'h30]), 32'(8'hA5));
    chk("abort_second_byte", 32'(mem[8'h31]), 32'(8'((8'h31 * 37 + 11) & 255)));

    for (int k = 0; k < 80; k++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(0, 16'hFEFF));
      else a = 16'($urandom_range(16'hFF00, 16'hFFFF));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             1'b0, 32'h0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (3) @(negedge Clk);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("final_memory_image", 32'(nbad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
